ram_dump_ctrl: RTL and testbench



---
 rtl/ram_dump_ctrl.sv | 141 ++++++++++++++
 tb/tb_ram_dump_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_ctrl.sv
// Streams one channel's circular capture RAM to the UART TX, oldest sample first,
// one byte per trmt/tx_done handshake.
module ram_dump_ctrl #(
  parameter int unsigned ENTRIES  = 384,
  parameter int unsigned LOG2     = 9,
  parameter int unsigned CHANNELS = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic [2:0]      dump_chan,
  input  logic            dump_abort,
  input  logic [LOG2-1:0] waddr_last,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic [2:0]      chan_sel,
  output logic [LOG2-1:0] raddr,
  output logic            rd_en,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            dump_busy,
  output logic            dump_done,
  output logic            dump_err
);

  typedef enum logic [1:0] {StIdle, StRead, StLatch, StWaitTx} state_e;

  // Last valid address doubles as the final byte index.
  localparam logic [LOG2-1:0] LastIdx = LOG2'(ENTRIES - 1);

  state_e          state_q, state_d;
  logic [LOG2-1:0] byte_cnt_q, byte_cnt_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [2:0]      chan_sel_q, chan_sel_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            trmt_q, trmt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic chan_valid;
  logic waddr_valid;

  assign chan_valid  = 32'(dump_chan) < CHANNELS;
  assign waddr_valid = 32'(waddr_last) < ENTRIES;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    raddr_d    = raddr_q;
    chan_sel_d = chan_sel_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    trmt_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          if (chan_valid) begin
            chan_sel_d = dump_chan;
            raddr_d    = waddr_valid ? waddr_last : '0;
            byte_cnt_d = '0;
            busy_d     = 1'b1;
            state_d    = StRead;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRead: begin
        state_d = StLatch;
      end
      StLatch: begin
        tx_data_d = rdata;
        trmt_d    = 1'b1;
        state_d   = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          if (byte_cnt_q == LastIdx) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            // Wrap at the RAM depth, which need not be a power of two.
            raddr_d    = (raddr_q == LastIdx) ? '0 : raddr_q + 1'b1;
            state_d    = StRead;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a coincident tx_done.
    if (dump_abort && (state_q != StIdle)) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      trmt_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      raddr_q    <= '0;
      chan_sel_q <= '0;
      tx_data_q  <= '0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      raddr_q    <= raddr_d;
      chan_sel_q <= chan_sel_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_en     = (state_q == StRead);
  assign chan_sel  = chan_sel_q;
  assign raddr     = raddr_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign dump_busy = busy_q;
  assign dump_done = done_q;
  assign dump_err  = err_q;

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Scoreboard bench for ram_dump_ctrl: expected bytes are queued per dump from a RAM model
// and popped by an independent monitor on every trmt.
module tb_ram_dump_ctrl;

  localparam int ENTRIES  = 384;
  localparam int LOG2     = 9;
  localparam int CHANNELS = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dump_start = 1'b0;
  logic [2:0]      dump_chan = '0;
  logic            dump_abort = 1'b0;
  logic [LOG2-1:0] waddr_last = '0;
  logic [7:0]      rdata = '0;
  logic            tx_done = 1'b0;
  logic [2:0]      chan_sel;
  logic [LOG2-1:0] raddr;
  logic            rd_en;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            dump_busy;
  logic            dump_done;
  logic            dump_err;

  always #5 clk = ~clk;

  ram_dump_ctrl #(
    .ENTRIES  (ENTRIES),
    .LOG2     (LOG2),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_chan  (dump_chan),
    .dump_abort (dump_abort),
    .waddr_last (waddr_last),
    .rdata      (rdata),
    .tx_done    (tx_done),
    .chan_sel   (chan_sel),
    .raddr      (raddr),
    .rd_en      (rd_en),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .dump_err   (dump_err)
  );

  // Channel RAMs: synchronous read, data one cycle after rd_en.
  logic [7:0] mem [8][512];
  always @(posedge clk) if (rd_en) rdata <= mem[chan_sel][raddr];

  typedef struct {
    logic [2:0]      chan;
    logic [LOG2-1:0] addr;
    logic [7:0]      data;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done = 0;
  int   tests = 0;
  int   fails = 0;
  bit   err_ok = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // UART responder: tx_done some cycles after each trmt, optionally with a coincident abort.
  int dly_lo = 0;
  int dly_hi = 6;
  int tx_pulses = 0;
  int abort_at = 0;
  bit abort_fired = 0;

  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (trmt) begin
        d = int'($urandom_range(dly_hi, dly_lo));
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
        end
        tx_pulses++;
        tx_done = 1'b1;
        if (abort_at != 0 && tx_pulses == abort_at) begin
          dump_abort = 1'b1;
          exp_q.delete();
          if (exp_done > 0) exp_done--;
          abort_fired = 1;
          abort_at = 0;
        end
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        dump_abort = 1'b0;
      end
    end
  end

  // Monitor
  logic [1:0] rd_hist = '0;
  logic       txd_s = 1'b0;
  always @(posedge clk) txd_s <= tx_done;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (trmt) begin
        check("rd_en to trmt latency", 32'(rd_hist[1]), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected trmt", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("chan_sel", 32'(chan_sel), 32'(e.chan));
          check("raddr", 32'(raddr), 32'(e.addr));
          check("tx_data", 32'(tx_data), 32'(e.data));
        end
      end
      if (dump_done) begin
        check("dump_done expected", 32'(exp_done > 0), 32'd1);
        check("dump_done one cycle after tx_done", 32'(txd_s), 32'd1);
        check("bytes left at dump_done", 32'(exp_q.size()), 32'd0);
        if (exp_done > 0) exp_done--;
      end
      if (dump_err) check("dump_err expected", 32'(err_ok), 32'd1);
      rd_hist = {rd_hist[0], rd_en};
    end
  end

  task automatic check_all_zero(input string name);
    check({name, " outputs"}, 32'({chan_sel, raddr, rd_en, tx_data, trmt, dump_busy,
                                   dump_done, dump_err}), 32'd0);
  endtask

  task automatic start_dump(input logic [2:0] ch, input logic [LOG2-1:0] wa);
    bit accept;
    int start;
    int a;
    exp_t e;
    @(posedge clk);
    #1;
    accept = (exp_done == 0) && (int'(ch) < CHANNELS);
    dump_start = 1'b1;
    dump_chan  = ch;
    waddr_last = wa;
    if (accept) begin
      start = (int'(wa) >= ENTRIES) ? 0 : int'(wa);
      for (int i = 0; i < ENTRIES; i++) begin
        a = (start + i) % ENTRIES;
        e.chan = ch;
        e.addr = LOG2'(a);
        e.data = mem[ch][a];
        exp_q.push_back(e);
      end
      exp_done++;
    end
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    @(negedge clk);
    if (accept) begin
      check("first rd_en latency", 32'(rd_en), 32'd1);
      check("chan_sel latched", 32'(chan_sel), 32'(ch));
      check("dump_busy at start", 32'(dump_busy), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_done > 0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("dump completed in time", 32'(exp_done == 0), 32'd1);
    @(negedge clk);
    check("dump_busy after dump", 32'(dump_busy), 32'd0);
  endtask

  initial begin
    int n;
    int errs;
    int act;
    for (int c = 0; c < 8; c++)
      for (int a = 0; a < 512; a++) mem[c][a] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after reset");

    // Linear dump from address 0, fixed UART time.
    dly_lo = 10;
    dly_hi = 10;
    start_dump(3'd2, 9'd0);
    wait_idle();

    // Wrap near the top of the RAM, random UART time.
    dly_lo = 0;
    dly_hi = 6;
    start_dump(3'($urandom_range(4, 0)), 9'd380);
    wait_idle();

    // Invalid channel.
    err_ok = 1;
    @(posedge clk);
    #1;
    dump_start = 1'b1;
    dump_chan  = 3'd5;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    errs = 0;
    act  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      errs += int'(dump_err);
      act  += int'(rd_en) + int'(trmt) + int'(dump_busy);
    end
    check("dump_err pulse width", 32'(errs), 32'd1);
    check("activity on bad channel", 32'(act), 32'd0);
    err_ok = 0;

    // Restart attempt mid-dump is ignored.
    start_dump(3'($urandom_range(4, 0)), 9'($urandom_range(383, 0)));
    n = 0;
    while (exp_q.size() > ENTRIES - 50 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("reached byte 50", 32'(exp_q.size() <= ENTRIES - 50), 32'd1);
    start_dump(3'd3, 9'd17);
    wait_idle();

    // Abort coincident with the 11th tx_done, then a full restart.
    dly_lo = 1;
    dly_hi = 6;
    tx_pulses = 0;
    abort_at = 11;
    start_dump(3'd1, 9'd200);
    n = 0;
    while (!abort_fired && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort issued", 32'(abort_fired), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("dump_busy after abort", 32'(dump_busy), 32'd0);
    check("trmt after abort", 32'(trmt), 32'd0);
    repeat (20) @(negedge clk);
    start_dump(3'd1, 9'd200);
    wait_idle();

    // Out-of-range write pointer restarts from 0.
    dly_lo = 0;
    dly_hi = 4;
    start_dump(3'd4, 9'd450);
    wait_idle();

    // Reset during WAIT_TX; the late tx_done must not restart anything.
    dly_lo = 10;
    dly_hi = 10;
    start_dump(3'd0, 9'($urandom_range(383, 0)));
    n = 0;
    while (!trmt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("trmt before reset", 32'(trmt), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_done = 0;
    #1;
    check_all_zero("async reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      act += int'(trmt) + int'(dump_busy) + int'(rd_en);
    end
    check("activity after reset release", 32'(act), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
